// File: rtl/uart_key_ctrl_pkg.sv
// rtl/uart_key_ctrl_pkg.sv - shared encodings and key decoder for the snake key controller
package uart_key_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Lowercase ASCII keys; uppercase is folded onto these by setting bit 5.
  localparam logic [7:0] KEY_W = 8'h77;
  localparam logic [7:0] KEY_D = 8'h64;
  localparam logic [7:0] KEY_S = 8'h73;
  localparam logic [7:0] KEY_A = 8'h61;
  localparam logic [7:0] KEY_P = 8'h70;
  localparam logic [7:0] KEY_R = 8'h72;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_DECODE = 1'b1;

  typedef enum logic [1:0] {
    KEY_NONE,
    KEY_DIR,
    KEY_PAUSE,
    KEY_RESTART
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [1:0] dir;
  } key_cmd_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  function automatic key_cmd_t decode_key(input logic [7:0] b);
    key_cmd_t   c;
    logic [7:0] lower;
    lower  = b | 8'h20;
    c.kind = KEY_NONE;
    c.dir  = DIR_UP;
    case (lower)
      KEY_W: begin c.kind = KEY_DIR; c.dir = DIR_UP;    end
      KEY_D: begin c.kind = KEY_DIR; c.dir = DIR_RIGHT; end
      KEY_S: begin c.kind = KEY_DIR; c.dir = DIR_DOWN;  end
      KEY_A: begin c.kind = KEY_DIR; c.dir = DIR_LEFT;  end
      KEY_P: c.kind = KEY_PAUSE;
      KEY_R: c.kind = KEY_RESTART;
      default: c.kind = KEY_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_key_ctrl_if.sv
// rtl/uart_key_ctrl_if.sv - RX FIFO and game-side signals of the snake key controller
interface uart_key_ctrl_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       game_tick;
  logic [1:0] dir;
  logic       pause_toggle;
  logic       restart;
  logic [7:0] key_data;
  logic [3:0] q_count;
  logic       overflow;

  modport master (
    output rx_empty, r_data, game_tick,
    input  rd_uart, dir, pause_toggle, restart, key_data, q_count, overflow
  );

  modport slave (
    input  rx_empty, r_data, game_tick,
    output rd_uart, dir, pause_toggle, restart, key_data, q_count, overflow
  );
endinterface

// File: rtl/uart_key_ctrl_dir_queue.sv
// rtl/uart_key_ctrl_dir_queue.sv - DEPTH x 2-bit direction FIFO with flush and tail peek
module uart_key_ctrl_dir_queue #(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [1:0]    din,
  output logic [1:0]    head,
  output logic [1:0]    tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] last_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign last_ptr = wr_ptr - AW'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[last_ptr];
  assign count    = cnt;

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_key_ctrl.sv
// rtl/uart_key_ctrl.sv - pops RX FIFO bytes, decodes snake keys, queues direction changes
module uart_key_ctrl
  import uart_key_ctrl_pkg::*;
#(
  parameter logic [1:0] INIT_DIR = DIR_RIGHT,
  parameter int         DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  uart_key_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [0:0]    state;
  logic [7:0]    byte_q;
  logic [7:0]    key_data_q;
  logic          rd_uart_q;
  logic          pause_q;
  logic          restart_q;
  logic          overflow_q;
  logic [1:0]    dir_q;

  key_cmd_t      cmd;
  logic          in_decode;
  logic [1:0]    ref_dir;
  logic          dir_ok;
  logic          do_restart;
  logic          q_push;
  logic          q_pop;
  logic [1:0]    q_head;
  logic [1:0]    q_tail;
  logic [CW-1:0] q_cnt;
  logic          q_full;
  logic          q_empty;

  // A new direction is compared against the last queued one, so a burst of
  // keys inside one game step cannot build a reversal.
  always_comb begin
    cmd        = decode_key(byte_q);
    in_decode  = (state == ST_DECODE);
    ref_dir    = q_empty ? dir_q : q_tail;
    dir_ok     = (cmd.kind == KEY_DIR) && (cmd.dir != ref_dir) &&
                 (cmd.dir != opposite(ref_dir));
    do_restart = in_decode && (cmd.kind == KEY_RESTART);
    q_push     = in_decode && dir_ok && !q_full;
    q_pop      = bus.game_tick && !q_empty && !do_restart;
  end

  uart_key_ctrl_dir_queue #(.DEPTH(DEPTH)) u_dir_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (do_restart),
    .din   (cmd.dir),
    .head  (q_head),
    .tail  (q_tail),
    .count (q_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      byte_q     <= '0;
      key_data_q <= '0;
      rd_uart_q  <= 1'b0;
      pause_q    <= 1'b0;
      restart_q  <= 1'b0;
      overflow_q <= 1'b0;
      dir_q      <= INIT_DIR;
    end else begin
      rd_uart_q <= 1'b0;
      pause_q   <= 1'b0;
      restart_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.rx_empty) begin
            byte_q     <= bus.r_data;
            key_data_q <= bus.r_data;
            rd_uart_q  <= 1'b1;
            state      <= ST_DECODE;
          end
        end
        default: begin
          pause_q   <= (cmd.kind == KEY_PAUSE);
          restart_q <= (cmd.kind == KEY_RESTART);
          if (do_restart)
            overflow_q <= 1'b0;
          else if (dir_ok && q_full)
            overflow_q <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
      if (do_restart)
        dir_q <= INIT_DIR;
      else if (q_pop)
        dir_q <= q_head;
    end
  end

  assign bus.rd_uart      = rd_uart_q;
  assign bus.dir          = dir_q;
  assign bus.pause_toggle = pause_q;
  assign bus.restart      = restart_q;
  assign bus.key_data     = key_data_q;
  assign bus.q_count      = 4'(q_cnt);
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_uart_key_ctrl.sv
// tb/tb_uart_key_ctrl.sv - directed vector bench for uart_key_ctrl (INIT_DIR=01, DEPTH=2)
module tb_uart_key_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_key_ctrl_if u_if ();

  uart_key_ctrl #(.INIT_DIR(2'b01), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         send;
    logic [7:0] key;
    bit         tick;
    logic [1:0] e_dir;
    logic [3:0] e_cnt;
    bit         e_ov;
    bit         e_pause;
    bit         e_rst;
    logic [7:0] e_kd;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    check({t, " dir"},          32'(u_if.dir),          32'(v.e_dir));
    check({t, " q_count"},      32'(u_if.q_count),      32'(v.e_cnt));
    check({t, " overflow"},     32'(u_if.overflow),     32'(v.e_ov));
    check({t, " pause_toggle"}, 32'(u_if.pause_toggle), 32'(v.e_pause));
    check({t, " restart"},      32'(u_if.restart),      32'(v.e_rst));
    check({t, " key_data"},     32'(u_if.key_data),     32'(v.e_kd));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    if (v.send) begin
      @(negedge clk);
      u_if.r_data   = v.key;
      u_if.rx_empty = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!u_if.rd_uart && n < 8);
      check($sformatf("v%0d rd_uart_high", idx), 32'(u_if.rd_uart), 32'd1);
      u_if.game_tick = v.tick;
      @(negedge clk);
      u_if.game_tick = 1'b0;
      u_if.rx_empty  = 1'b1;
      check($sformatf("v%0d rd_uart_one_cycle", idx), 32'(u_if.rd_uart), 32'd0);
    end else begin
      @(negedge clk);
      u_if.game_tick = 1'b1;
      @(negedge clk);
      u_if.game_tick = 1'b0;
    end
    check_outputs(idx, v);
    @(negedge clk);
    check($sformatf("v%0d pulses_cleared", idx),
          32'({u_if.pause_toggle, u_if.restart, u_if.rd_uart}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int rd_seen;
    //           send key    tick dir    cnt   ov pause rst kd
    vecs[0]  = '{1, 8'h77, 0, 2'b01, 4'd1, 0, 0, 0, 8'h77};
    vecs[1]  = '{0, 8'h00, 1, 2'b00, 4'd0, 0, 0, 0, 8'h77};
    vecs[2]  = '{1, 8'h52, 0, 2'b01, 4'd0, 0, 0, 1, 8'h52};
    vecs[3]  = '{1, 8'h61, 0, 2'b01, 4'd0, 0, 0, 0, 8'h61};
    vecs[4]  = '{1, 8'h64, 0, 2'b01, 4'd0, 0, 0, 0, 8'h64};
    vecs[5]  = '{1, 8'h73, 0, 2'b01, 4'd1, 0, 0, 0, 8'h73};
    vecs[6]  = '{1, 8'h61, 0, 2'b01, 4'd2, 0, 0, 0, 8'h61};
    vecs[7]  = '{0, 8'h00, 1, 2'b10, 4'd1, 0, 0, 0, 8'h61};
    vecs[8]  = '{0, 8'h00, 1, 2'b11, 4'd0, 0, 0, 0, 8'h61};
    vecs[9]  = '{1, 8'h72, 0, 2'b01, 4'd0, 0, 0, 1, 8'h72};
    vecs[10] = '{1, 8'h77, 0, 2'b01, 4'd1, 0, 0, 0, 8'h77};
    vecs[11] = '{1, 8'h61, 0, 2'b01, 4'd2, 0, 0, 0, 8'h61};
    vecs[12] = '{1, 8'h73, 0, 2'b01, 4'd2, 1, 0, 0, 8'h73};
    vecs[13] = '{1, 8'h31, 0, 2'b01, 4'd2, 1, 0, 0, 8'h31};
    vecs[14] = '{1, 8'h52, 1, 2'b01, 4'd0, 0, 0, 1, 8'h52};
    vecs[15] = '{1, 8'h50, 0, 2'b01, 4'd0, 0, 1, 0, 8'h50};
    vecs[16] = '{1, 8'h31, 0, 2'b01, 4'd0, 0, 0, 0, 8'h31};
    vecs[17] = '{1, 8'h57, 0, 2'b01, 4'd1, 0, 0, 0, 8'h57};
    vecs[18] = '{1, 8'h64, 1, 2'b00, 4'd1, 0, 0, 0, 8'h64};
    vecs[19] = '{1, 8'h73, 1, 2'b01, 4'd1, 0, 0, 0, 8'h73};
    vecs[20] = '{0, 8'h00, 1, 2'b10, 4'd0, 0, 0, 0, 8'h73};
    vecs[21] = '{1, 8'h61, 1, 2'b10, 4'd1, 0, 0, 0, 8'h61};
    vecs[22] = '{0, 8'h00, 1, 2'b11, 4'd0, 0, 0, 0, 8'h61};
    vecs[23] = '{1, 8'h53, 0, 2'b11, 4'd1, 0, 0, 0, 8'h53};
    vecs[24] = '{1, 8'h77, 0, 2'b11, 4'd1, 0, 0, 0, 8'h77};
    vecs[25] = '{1, 8'h44, 0, 2'b11, 4'd2, 0, 0, 0, 8'h44};

    // Reset held with a byte waiting: nothing may be popped.
    u_if.rx_empty  = 1'b0;
    u_if.r_data    = 8'h77;
    u_if.game_tick = 1'b0;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    check("reset dir",      32'(u_if.dir),      32'h1);
    check("reset rd_uart",  32'(u_if.rd_uart),  32'h0);
    check("reset key_data", 32'(u_if.key_data), 32'h0);
    check("reset q_count",  32'(u_if.q_count),  32'h0);
    check("reset overflow", 32'(u_if.overflow), 32'h0);
    check("reset pulses",   32'({u_if.pause_toggle, u_if.restart}), 32'h0);

    rst           = 1'b1;
    u_if.rx_empty = 1'b1;
    rd_seen       = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.rd_uart) rd_seen++;
    end
    check("idle rd_uart count", 32'(rd_seen), 32'd0);

    for (int i = 0; i < 26; i++) run_vec(i, vecs[i]);

    // Reset asserted while a popped byte is in DECODE: the byte is lost.
    @(negedge clk);
    u_if.r_data   = 8'h77;
    u_if.rx_empty = 1'b0;
    @(negedge clk);
    check("midop rd_uart_before", 32'(u_if.rd_uart), 32'd1);
    rst = 1'b0;
    #1;
    check("midop rd_uart",  32'(u_if.rd_uart),  32'h0);
    check("midop dir",      32'(u_if.dir),      32'h1);
    check("midop q_count",  32'(u_if.q_count),  32'h0);
    check("midop key_data", 32'(u_if.key_data), 32'h0);
    u_if.rx_empty = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("after midop q_count", 32'(u_if.q_count), 32'h0);
    check("after midop dir",     32'(u_if.dir),     32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
